// File: rtl/oled_byte_writer.sv
// oled_byte_writer: responder side of the sendData/sendDataValid/sendDone
// four-phase handshake. Each accepted byte is shifted MSB-first onto the OLED
// SPI pins as display data. At column 0 of a page, a three-byte page-address
// command sequence is sent ahead of the data byte.
module oled_byte_writer #(
  parameter int unsigned CLK_DIV = 5,
  parameter int unsigned COLS    = 128,
  parameter int unsigned PAGES   = 4,
  localparam int unsigned PW     = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int unsigned CW     = $clog2(COLS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    sendData,
  input  logic          sendDataValid,
  output logic          sendDone,
  output logic          oled_spi_clk,
  output logic          oled_spi_data,
  output logic          oled_dc_n,
  output logic [PW-1:0] cursor_page,
  output logic [CW-1:0] cursor_col
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StAck} state_e;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;     // byte currently on the wire, MSB next
  logic [7:0]    byte_q, byte_d;       // latched display byte
  logic [1:0]    cmd_idx_q, cmd_idx_d; // which command byte is being sent
  logic [DW-1:0] div_q, div_d;         // cycles within the current half-period
  logic          half_q, half_d;       // 0: SCLK low half, 1: SCLK high half
  logic [2:0]    bit_q, bit_d;         // bit index within the byte
  logic          tail_q, tail_d;       // data byte fully sent, ack next cycle
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          dc_q, dc_d;
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;

  logic last_div;
  logic bit_done;
  logic byte_end;
  logic col_last;
  logic page_last;

  assign last_div  = (div_q == DW'(CLK_DIV - 1));
  assign bit_done  = last_div & half_q;
  assign byte_end  = bit_done & (bit_q == 3'd7);
  assign col_last  = (col_q == CW'(COLS - 1));
  assign page_last = (page_q == PW'(PAGES - 1));

  // Next-state logic for the handshake FSM, serializer and cursor
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    cmd_idx_d = cmd_idx_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_d     = bit_q;
    tail_d    = tail_q;
    done_d    = done_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    dc_d      = dc_q;
    page_d    = page_q;
    col_d     = col_q;

    unique case (state_q)
      StIdle: begin
        if (sendDataValid && !done_q) begin
          byte_d    = sendData;
          div_d     = '0;
          half_d    = 1'b0;
          bit_d     = 3'd0;
          tail_d    = 1'b0;
          cmd_idx_d = 2'd0;
          if (col_q == '0) begin
            state_d = StCmd;
            shreg_d = 8'hB0 | 8'(page_q);
          end else begin
            state_d = StData;
            shreg_d = sendData;
          end
        end
      end

      StCmd, StData: begin
        if (tail_q) begin
          // Byte has finished; SCLK already rests high and MOSI holds
          tail_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StAck;
          if (col_last) begin
            col_d  = '0;
            page_d = page_last ? '0 : page_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          // dc follows the state so it only changes at a byte boundary
          sclk_d = half_q;
          mosi_d = shreg_q[7];
          dc_d   = (state_q == StData);

          div_d = last_div ? '0 : div_q + 1'b1;
          if (last_div) begin
            half_d = ~half_q;
          end
          if (bit_done) begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end

          if (byte_end) begin
            if (state_q == StCmd) begin
              if (cmd_idx_q == 2'd2) begin
                state_d = StData;
                shreg_d = byte_q;
              end else begin
                cmd_idx_d = cmd_idx_q + 2'd1;
                shreg_d   = (cmd_idx_q == 2'd0) ? 8'h00 : 8'h10;
              end
            end else begin
              tail_d = 1'b1;
            end
          end
        end
      end

      StAck: begin
        if (!sendDataValid) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= 8'h00;
      byte_q    <= 8'h00;
      cmd_idx_q <= 2'd0;
      div_q     <= '0;
      half_q    <= 1'b0;
      bit_q     <= 3'd0;
      tail_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b1;
      page_q    <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      cmd_idx_q <= cmd_idx_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      tail_q    <= tail_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      dc_q      <= dc_d;
      page_q    <= page_d;
      col_q     <= col_d;
    end
  end

  assign sendDone      = done_q;
  assign oled_spi_clk  = sclk_q;
  assign oled_spi_data = mosi_q;
  assign oled_dc_n     = dc_q;
  assign cursor_page   = page_q;
  assign cursor_col    = col_q;

endmodule

// File: tb/tb_oled_byte_writer.sv
// Bench for oled_byte_writer: a default-sized instance driven with directed and
// random handshakes against a transaction/deadline model, plus a small
// COLS=4/PAGES=2 instance for cursor wrap.
module tb_oled_byte_writer;

  localparam int ACD = 5, ACOLS = 128, APAGES = 4;
  localparam int BCD = 1, BCOLS = 4, BPAGES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default geometry
  logic       rst_a, a_valid, a_done, a_sclk, a_mosi, a_dc;
  logic [7:0] a_data;
  logic [1:0] a_page;
  logic [6:0] a_col;

  oled_byte_writer #(.CLK_DIV(ACD), .COLS(ACOLS), .PAGES(APAGES)) u_a (
    .clock(clk), .reset(rst_a), .sendData(a_data), .sendDataValid(a_valid),
    .sendDone(a_done), .oled_spi_clk(a_sclk), .oled_spi_data(a_mosi),
    .oled_dc_n(a_dc), .cursor_page(a_page), .cursor_col(a_col)
  );

  // Instance B: small geometry for wrap
  logic       rst_b, b_valid, b_done, b_sclk, b_mosi, b_dc;
  logic [7:0] b_data;
  logic [0:0] b_page;
  logic [1:0] b_col;

  oled_byte_writer #(.CLK_DIV(BCD), .COLS(BCOLS), .PAGES(BPAGES)) u_b (
    .clock(clk), .reset(rst_b), .sendData(b_data), .sendDataValid(b_valid),
    .sendDone(b_done), .oled_spi_clk(b_sclk), .oled_spi_data(b_mosi),
    .oled_dc_n(b_dc), .cursor_page(b_page), .cursor_col(b_col)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of A: expected byte stream plus the edge at which sendDone must rise
  int         c = 0;
  logic       m_done = 1'b0;
  int         m_done_at = -1;
  int         m_page = 0, m_col = 0, m_acc = 0;
  logic [8:0] a_exp[$];
  logic [8:0] a_log[$];
  int         a_nb = 0;
  logic [7:0] a_sh;
  logic       a_dc0;

  initial forever begin
    @(posedge clk);
    c = c + 1;
    if (rst_a) begin
      m_done = 1'b0; m_done_at = -1; m_page = 0; m_col = 0;
      a_exp.delete(); a_nb = 0;
    end else if (m_done) begin
      if (!a_valid) m_done = 1'b0;
    end else if (m_done_at == c) begin
      m_done = 1'b1; m_done_at = -1;
      if (m_col == ACOLS - 1) begin
        m_col = 0; m_page = (m_page + 1) % APAGES;
      end else begin
        m_col = m_col + 1;
      end
    end else if (m_done_at < 0 && a_valid) begin
      m_acc = c;
      if (m_col == 0) begin
        a_exp.push_back({1'b0, 8'hB0 | 8'(m_page)});
        a_exp.push_back(9'h000);
        a_exp.push_back(9'h010);
        m_done_at = c + 1 + 16 * ACD * 4;
      end else begin
        m_done_at = c + 1 + 16 * ACD;
      end
      a_exp.push_back({1'b1, a_data});
    end
  end

  // SPI decoder for A: sample MOSI on each SCLK rising edge
  initial forever begin
    logic [8:0] want;
    @(posedge a_sclk);
    if (!rst_a) begin
      if (a_nb == 0) a_dc0 = a_dc;
      else check("dc_stable", a_dc, a_dc0);
      a_sh = {a_sh[6:0], a_mosi};
      a_nb++;
      if (a_nb == 8) begin
        a_nb = 0;
        a_log.push_back({a_dc0, a_sh});
        if (a_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL a_byte: got unexpected %h expected none", {a_dc0, a_sh});
        end else begin
          want = a_exp.pop_front();
          check("a_byte", {a_dc0, a_sh}, want);
        end
      end
    end
  end

  // Per-cycle compare of A against the model, plus sendDone pulse tracking
  int   a_rise = -1, a_run = 0, a_last_run = 0;
  logic a_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (c >= 1) begin
      check("sendDone", a_done, m_done);
      check("cursor_page", a_page, m_page);
      check("cursor_col", a_col, m_col);
      if (m_done_at < 0) check("sclk_idle", a_sclk, 1);
      if (a_done && !a_prev) begin a_rise = c; a_run = 0; end
      if (a_done) a_run++;
      if (!a_done && a_prev) a_last_run = a_run;
      a_prev = a_done;
    end
  end

  // SPI decoder for B: log only, checked against an arithmetic list later
  logic [8:0] b_log[$];
  int         b_nb = 0;
  logic [7:0] b_sh;
  initial forever begin
    @(posedge b_sclk);
    if (!rst_b) begin
      b_sh = {b_sh[6:0], b_mosi};
      b_nb++;
      if (b_nb == 8) begin b_nb = 0; b_log.push_back({b_dc, b_sh}); end
    end
  end

  task automatic wait_a(input logic lvl, input string what);
    int n = 0;
    while (a_done !== lvl && n < 2000) begin @(negedge clk); n++; end
    if (a_done !== lvl) begin
      total++; bad++;
      $display("FAIL %s: sendDone=%b after %0d cycles expected %b", what, a_done, n, lvl);
    end
  endtask

  task automatic a_send(input logic [7:0] d, input int hold, input bit early);
    @(negedge clk);
    a_data = d; a_valid = 1'b1;
    if (early) begin repeat (3) @(negedge clk); a_valid = 1'b0; end
    wait_a(1'b1, "a_rise_timeout");
    if (!early) begin repeat (hold) @(negedge clk); a_valid = 1'b0; end
    wait_a(1'b0, "a_fall_timeout");
  endtask

  task automatic b_send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    b_data = d; b_valid = 1'b1;
    while (b_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (b_done !== 1'b1) begin
      total++; bad++;
      $display("FAIL b_rise_timeout: sendDone=%b expected 1", b_done);
    end
    b_valid = 1'b0;
    n = 0;
    while (b_done !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    if (b_done !== 1'b0) begin
      total++; bad++;
      $display("FAIL b_fall_timeout: sendDone=%b expected 0", b_done);
    end
  endtask

  initial begin
    int         sz;
    logic [7:0] bd[9];
    logic [8:0] bexp[$];

    rst_a = 1'b1; a_valid = 1'b0; a_data = 8'h00;
    rst_b = 1'b1; b_valid = 1'b0; b_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("rst_done", a_done, 0);
    check("rst_sclk", a_sclk, 1);
    check("rst_mosi", a_mosi, 0);
    check("rst_dc", a_dc, 1);

    // First byte after reset, valid seen at edge 10
    while (c < 9) @(negedge clk);
    a_data = 8'h43; a_valid = 1'b1;
    wait_a(1'b1, "first_rise_timeout");
    a_valid = 1'b0;
    wait_a(1'b0, "first_fall_timeout");
    @(negedge clk);
    check("first_rise_edge", a_rise, 331);
    check("first_log_size", a_log.size(), 4);
    if (a_log.size() >= 4) begin
      check("first_cmd0", a_log[0], 9'h0B0);
      check("first_cmd1", a_log[1], 9'h000);
      check("first_cmd2", a_log[2], 9'h010);
      check("first_data", a_log[3], 9'h143);
    end
    check("first_page", a_page, 0);
    check("first_col", a_col, 1);

    // Advance to column 5, then a mid-page byte
    repeat (4) a_send(8'($urandom), $urandom_range(0, 3), 1'b0);
    check("mid_col_before", a_col, 5);
    sz = a_log.size();
    a_send(8'hA5, 0, 1'b0);
    @(negedge clk);
    check("mid_no_cmd", a_log.size(), sz + 1);
    check("mid_byte", a_log[a_log.size() - 1], 9'h1A5);
    check("mid_latency", a_rise - m_acc, 81);

    // Valid held 20 cycles after sendDone rises
    sz = a_log.size();
    a_send(8'($urandom), 20, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_run", a_last_run, 21);
    check("hold_one_xfer", a_log.size(), sz + 1);

    // Valid dropped mid-byte
    a_send(8'($urandom), 0, 1'b1);
    @(negedge clk);
    check("early_run", a_last_run, 1);

    // sendData changes right after accept
    @(negedge clk);
    a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_data = 8'hFF;
    wait_a(1'b1, "stab_rise_timeout");
    a_valid = 1'b0;
    wait_a(1'b0, "stab_fall_timeout");
    @(negedge clk);
    check("stable_byte", a_log[a_log.size() - 1], 9'h13C);

    // Random traffic
    for (int i = 0; i < 25; i++) begin
      a_send(8'($urandom), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end

    // Reset during bit 3 of a data byte
    @(negedge clk);
    a_data = 8'($urandom); a_valid = 1'b1;
    @(negedge clk);
    repeat (33) @(negedge clk);
    rst_a = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_sclk", a_sclk, 1);
    check("mid_rst_mosi", a_mosi, 0);
    check("mid_rst_dc", a_dc, 1);
    check("mid_rst_page", a_page, 0);
    check("mid_rst_col", a_col, 0);
    rst_a = 1'b0;
    sz = a_log.size();
    a_send(8'h5A, 1, 1'b0);
    @(negedge clk);
    check("post_rst_size", a_log.size(), sz + 4);
    if (a_log.size() == sz + 4) begin
      check("post_rst_cmd0", a_log[sz], 9'h0B0);
      check("post_rst_cmd1", a_log[sz + 1], 9'h000);
      check("post_rst_cmd2", a_log[sz + 2], 9'h010);
      check("post_rst_data", a_log[sz + 3], 9'h15A);
    end
    check("a_pending", a_exp.size(), 0);

    // Wrap on the small instance: 9 back-to-back bytes
    for (int i = 0; i < 9; i++) begin
      bd[i] = 8'($urandom);
      b_send(bd[i]);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i % BCOLS == 0) begin
        bexp.push_back({1'b0, 8'hB0 | 8'((i / BCOLS) % BPAGES)});
        bexp.push_back(9'h000);
        bexp.push_back(9'h010);
      end
      bexp.push_back({1'b1, bd[i]});
    end
    check("wrap_size", b_log.size(), bexp.size());
    if (b_log.size() == 18) begin
      for (int i = 0; i < 18; i++) check("wrap_byte", b_log[i], bexp[i]);
      check("wrap_cmd_b1", b_log[0], 9'h0B0);
      check("wrap_cmd_b5", b_log[7], 9'h0B1);
      check("wrap_cmd_b9", b_log[14], 9'h0B0);
    end
    check("wrap_page", b_page, 0);
    check("wrap_col", b_col, 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oled_byte_writer.md
# oled_byte_writer

Responder end of the `sendData` / `sendDataValid` / `sendDone` byte handshake used by the display text path.
- Accepts one display-RAM byte per four-phase handshake and serializes it MSB-first over the OLED SPI pins with `oled_dc_n` = 1.
- Tracks a page/column cursor. At the start of every page it inserts a 3-byte page-address command sequence with `oled_dc_n` = 0.
- Sits between the string sequencer and the OLED pins. Power/reset sequencing of the panel is out of scope.

## Interface
- `CLK_DIV`, 5: system clocks per SPI clock half-period; must be ≥1. 5 gives 10 MHz SCLK from the 100 MHz clock.
- `COLS`, 128: data bytes per display page before the cursor wraps; must be ≥2.
- `PAGES`, 4: display pages; page index wraps modulo `PAGES`; must be ≥1.
- `clock`  in  1: 100 MHz system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sendData`  in  8: byte to write; sampled only on handshake accept.
- `sendDataValid`  in  1: request; held high by the initiator until `sendDone` is seen high.
- `sendDone`  out  1: acknowledge; high from transfer completion until `sendDataValid` is seen low.
- `oled_spi_clk`  out  1: SPI clock, idles high.
- `oled_spi_data`  out  1: SPI MOSI.
- `oled_dc_n`  out  1: 0 = command byte, 1 = data byte.
- `cursor_page`  out  $clog2(PAGES) (min 1): current page.
- `cursor_col`  out  $clog2(COLS): current column.

## Operation
- States: IDLE, CMD, DATA, ACK.
- **IDLE**
  - On a cycle with `sendDataValid`=1 and `sendDone`=0, latch `sendData`.
  - If `cursor_col`==0, go to CMD. Otherwise go to DATA.
- **CMD**
  - Send three bytes with `oled_dc_n`=0, in order: 0xB0 | `cursor_page`, then 0x00, then 0x10.
  - Then go to DATA.
- **DATA**
  - Send the latched byte with `oled_dc_n`=1.
  - Then advance the cursor: `cursor_col`+1. At `COLS`-1, `cursor_col` wraps to 0 and `cursor_page` becomes (`cursor_page`+1) mod `PAGES`.
  - Go to ACK.
- **ACK**
  - `sendDone`=1.
  - When `sendDataValid` is sampled 0, `sendDone` returns to 0 next cycle and the block re-enters IDLE.
- **Byte serializer**
  - 8 bits, MSB first.
  - Per bit: drive `oled_spi_data` and pull `oled_spi_clk` low for `CLK_DIV` cycles, then hold it high for `CLK_DIV` cycles. The panel samples on the rising edge.
- `oled_dc_n` is stable for the whole byte. Consecutive command/data bytes go back-to-back with no idle gap.
- Changes on `sendData` after accept are ignored.
- `sendDataValid` dropping before ACK is ignored: the transfer completes, and ACK then exits after one cycle of `sendDone`=1.
- While in ACK, the block accepts no new byte.

## Timing
- Reset values:
  - State: IDLE; `sendDone`=0; `oled_spi_clk`=1; `oled_spi_data`=0; `oled_dc_n`=1; `cursor_page`=0; `cursor_col`=0.
- Reset mid-transfer aborts immediately to these values. The partial byte is lost and `sendDone` is not asserted.
- Accept at rising edge N: the first falling edge of `oled_spi_clk` is visible after edge N+1.
- One byte lasts 16·`CLK_DIV` cycles.
- `sendDone` rises at edge N+1+16·`CLK_DIV`·B, where B=1 for data only and B=4 when the page command is inserted.
  - With `CLK_DIV`=5: N+81 for data only, N+321 with the command.
- `sendDone` falls one cycle after `sendDataValid` is sampled low in ACK. The earliest next accept is the cycle after that.
- After the last data bit, `oled_spi_clk` stays high and `oled_spi_data` holds its last value until the next byte.

## Test plan
- **First byte after reset:** valid with 0x43 at edge 10. Required response:
  - Command bits decode as 0xB0, 0x00, 0x10 with `oled_dc_n`=0, then 0x43 with `oled_dc_n`=1.
  - `sendDone` rises at edge 331.
  - Cursor reads 0/1 afterwards.
- **Mid-page byte:** at `cursor_col`=5, send 0xA5. Required response: no command bytes, 8 rising-edge samples read 1,0,1,0,0,1,0,1, `sendDone` rises 81 cycles after accept.
- **Wrap:** `COLS`=4, `PAGES`=2, 9 back-to-back bytes. Required response:
  - Page commands are 0xB0 before byte 1, 0xB1 before byte 5, and 0xB0 before byte 9.
  - The final cursor is 0/1.
- **Handshake protocol:**
  - Initiator holds valid 20 cycles after `sendDone` rises: `sendDone` stays high until one cycle after valid falls, with no second transfer.
  - Separately, valid dropped mid-byte: the byte completes and `sendDone` is high for exactly 1 cycle.
- **Data stability:** `sendData` changes from 0x3C to 0xFF one cycle after accept. Required response: the bits serialize as 0x3C.
- **Reset mid-transfer:** reset asserted during bit 3 of a data byte. Required response:
  - The next cycle shows all reset values.
  - The next accepted byte triggers the page-0 command sequence.
